// File: rtl/life_pkg.sv
// Shared constants, FSM state type and toroidal coordinate helpers for the Game of Life engine.
package life_pkg;

  localparam int DEF_COLS = 20;
  localparam int DEF_ROWS = 15;
  localparam int X_W      = 5;
  localparam int Y_W      = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    COMMIT = 2'd2
  } state_e;

  function automatic logic [X_W-1:0] inc_x(input logic [X_W-1:0] v, input logic [X_W-1:0] last);
    return (v == last) ? '0 : v + 1'b1;
  endfunction

  function automatic logic [X_W-1:0] dec_x(input logic [X_W-1:0] v, input logic [X_W-1:0] last);
    return (v == '0) ? last : v - 1'b1;
  endfunction

  function automatic logic [Y_W-1:0] inc_y(input logic [Y_W-1:0] v, input logic [Y_W-1:0] last);
    return (v == last) ? '0 : v + 1'b1;
  endfunction

  function automatic logic [Y_W-1:0] dec_y(input logic [Y_W-1:0] v, input logic [Y_W-1:0] last);
    return (v == '0) ? last : v - 1'b1;
  endfunction

endpackage

// File: rtl/life_if.sv
// Control, seed-write, display-read and status signals of the life engine.
interface life_if
  import life_pkg::*;
#(
  parameter int GEN_W = 16
) ();

  // start is a level request sampled only while idle (busy=0); no queuing while busy.
  // done pulses for one cycle after each commit; busy covers scan and commit.
  logic             start;
  logic             busy;
  logic             done;
  logic             wr_en;
  logic [X_W-1:0]   wr_x;
  logic [Y_W-1:0]   wr_y;
  logic             wr_data;
  logic [X_W-1:0]   rd_x;
  logic [Y_W-1:0]   rd_y;
  logic             rd_cell;
  logic [GEN_W-1:0] gen_count;
  state_e           dbg_state;

  modport master (
    output start, wr_en, wr_x, wr_y, wr_data, rd_x, rd_y,
    input  busy, done, rd_cell, gen_count, dbg_state
  );

  modport slave (
    input  start, wr_en, wr_x, wr_y, wr_data, rd_x, rd_y,
    output busy, done, rd_cell, gen_count, dbg_state
  );

endinterface

// File: rtl/life_rule.sv
// B3/S23 cell rule: counts the 8 neighbours of a 3x3 window (centre at bit 4) and decodes the next state.
module life_rule (
  input  logic [8:0] nbhd_i,
  output logic       alive_o
);

  logic [3:0] n;

  always_comb begin
    n = '0;
    for (int i = 0; i < 9; i++) begin
      if (i != 4) n = n + {3'b000, nbhd_i[i]};
    end
    alive_o = (n == 4'd3) || (nbhd_i[4] && (n == 4'd2));
  end

endmodule

// File: rtl/life_engine.sv
// Game of Life generation engine: cur plane is displayed and seeded, nxt plane is built one cell per clock
// during SCAN and copied into cur on COMMIT.
module life_engine
  import life_pkg::*;
#(
  parameter int COLS  = DEF_COLS,
  parameter int ROWS  = DEF_ROWS,
  parameter int GEN_W = 16
) (
  input  logic  clk,
  input  logic  reset,
  life_if.slave bus
);

  localparam logic [X_W-1:0] X_LAST = X_W'(COLS - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(ROWS - 1);

  state_e             state_q, state_d;
  logic [X_W-1:0]     sx_q, sx_d;
  logic [Y_W-1:0]     sy_q, sy_d;
  logic               done_q, done_d;
  logic [GEN_W-1:0]   gen_q, gen_d;
  logic [ROWS-1:0][COLS-1:0] cur_q, nxt_q;

  logic [X_W-1:0] xm, xp;
  logic [Y_W-1:0] ym, yp;
  logic [8:0]     nbhd;
  logic           rule_next;
  logic           seed_we;

  assign xm = dec_x(sx_q, X_LAST);
  assign xp = inc_x(sx_q, X_LAST);
  assign ym = dec_y(sy_q, Y_LAST);
  assign yp = inc_y(sy_q, Y_LAST);

  assign nbhd = {cur_q[yp][xp], cur_q[yp][sx_q], cur_q[yp][xm],
                 cur_q[sy_q][xp], cur_q[sy_q][sx_q], cur_q[sy_q][xm],
                 cur_q[ym][xp], cur_q[ym][sx_q], cur_q[ym][xm]};

  life_rule u_rule (
    .nbhd_i (nbhd),
    .alive_o(rule_next)
  );

  assign seed_we = (state_q == IDLE) && bus.wr_en &&
                   (bus.wr_x < X_W'(COLS)) && (bus.wr_y < Y_W'(ROWS));

  always_comb begin
    state_d = state_q;
    sx_d    = sx_q;
    sy_d    = sy_q;
    done_d  = 1'b0;
    gen_d   = gen_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = SCAN;
          sx_d    = '0;
          sy_d    = '0;
        end
      end
      SCAN: begin
        if (sx_q == X_LAST) begin
          sx_d = '0;
          if (sy_q == Y_LAST) begin
            sy_d    = '0;
            state_d = COMMIT;
          end else begin
            sy_d = sy_q + 1'b1;
          end
        end else begin
          sx_d = sx_q + 1'b1;
        end
      end
      COMMIT: begin
        done_d  = 1'b1;
        gen_d   = gen_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sx_q    <= '0;
      sy_q    <= '0;
      done_q  <= 1'b0;
      gen_q   <= '0;
    end else begin
      state_q <= state_d;
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      done_q  <= done_d;
      gen_q   <= gen_d;
    end
  end

  // Seed writes only happen in IDLE, so they never collide with the commit copy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_q <= '0;
      nxt_q <= '0;
    end else begin
      if (seed_we) cur_q[bus.wr_y][bus.wr_x] <= bus.wr_data;
      if (state_q == SCAN) nxt_q[sy_q][sx_q] <= rule_next;
      if (state_q == COMMIT) cur_q <= nxt_q;
    end
  end

  assign bus.rd_cell   = ((bus.rd_x < X_W'(COLS)) && (bus.rd_y < Y_W'(ROWS))) ?
                         cur_q[bus.rd_y][bus.rd_x] : 1'b0;
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = done_q;
  assign bus.gen_count = gen_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_life_engine.sv
// Self-checking bench for life_engine: directed patterns plus random soups against a toroidal Life model.
module tb_life_engine;
  import life_pkg::*;

  localparam int COLS  = 20;
  localparam int ROWS  = 15;
  localparam int GEN_W = 16;

  logic clk;
  logic reset;

  life_if #(.GEN_W(GEN_W)) bus ();

  life_engine #(.COLS(COLS), .ROWS(ROWS), .GEN_W(GEN_W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int gen_m  = 0;
  bit m [ROWS][COLS];
  logic [0:0] exp_q[$];

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int y = 0; y < ROWS; y++)
      for (int x = 0; x < COLS; x++) m[y][x] = 1'b0;
    gen_m = 0;
  endtask

  // Reference: count the 8 toroidal neighbours with modular arithmetic and apply B3/S23.
  task automatic model_step();
    bit t [ROWS][COLS];
    int n;
    for (int y = 0; y < ROWS; y++)
      for (int x = 0; x < COLS; x++) begin
        n = 0;
        for (int dy = -1; dy <= 1; dy++)
          for (int dx = -1; dx <= 1; dx++)
            if (dx != 0 || dy != 0)
              n += m[(y + dy + ROWS) % ROWS][(x + dx + COLS) % COLS];
        t[y][x] = (n == 3) || (m[y][x] && n == 2);
      end
    m = t;
    gen_m++;
  endtask

  // driver tasks
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    model_clear();
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_done", 32'(bus.done), 32'd0);
    chk("reset_gen", 32'(bus.gen_count), 32'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic write_cell(input int x, input int y, input bit v);
    @(negedge clk);
    bus.wr_en   = 1'b1;
    bus.wr_x    = X_W'(x);
    bus.wr_y    = Y_W'(y);
    bus.wr_data = v;
    if (x < COLS && y < ROWS) m[y][x] = v;
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask

  task automatic read_chk(input string tag, input int x, input int y, input bit exp);
    @(negedge clk);
    bus.rd_x = X_W'(x);
    bus.rd_y = Y_W'(y);
    #1;
    chk(tag, 32'(bus.rd_cell), 32'(exp));
  endtask

  // scoreboard: expected grid queued, then popped against the read port
  task automatic check_grid(input string tag);
    logic [0:0] e;
    for (int y = 0; y < ROWS; y++)
      for (int x = 0; x < COLS; x++) exp_q.push_back(m[y][x]);
    for (int y = 0; y < ROWS; y++)
      for (int x = 0; x < COLS; x++) begin
        e = exp_q.pop_front();
        read_chk($sformatf("%s_cell_%0d_%0d", tag, x, y), x, y, e);
      end
  endtask

  task automatic step_gen(input bit disturb, input bit co_write);
    int lat;
    int extra;
    @(negedge clk);
    bus.start = 1'b1;
    if (co_write) begin
      bus.wr_en = 1'b1; bus.wr_x = 5'd10; bus.wr_y = 4'd10; bus.wr_data = 1'b1;
      m[10][10] = 1'b1;
    end
    @(negedge clk);
    bus.start = 1'b0;
    bus.wr_en = 1'b0;
    chk("busy_after_start", 32'(bus.busy), 32'd1);
    lat = 0;
    while (!bus.done && lat < 400) begin
      if (disturb && lat == 50) begin
        bus.start = 1'b1; bus.wr_en = 1'b1;
        bus.wr_x = 5'd3; bus.wr_y = 4'd3; bus.wr_data = 1'b1;
      end else begin
        bus.start = 1'b0; bus.wr_en = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    bus.start = 1'b0;
    bus.wr_en = 1'b0;
    chk("done_latency", 32'(lat), 32'd301);
    chk("busy_at_done", 32'(bus.busy), 32'd0);
    model_step();
    chk("gen_count", 32'(bus.gen_count), 32'(gen_m & 16'hFFFF));
    @(negedge clk);
    chk("done_one_cycle", 32'(bus.done), 32'd0);
    chk("busy_after_done", 32'(bus.busy), 32'd0);
    if (disturb) begin
      extra = 0;
      repeat (320) begin
        @(negedge clk);
        if (bus.done) extra++;
      end
      chk("no_extra_done", 32'(extra), 32'd0);
    end
  endtask

  initial begin
    reset       = 1'b1;
    bus.start   = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wr_x    = '0;
    bus.wr_y    = '0;
    bus.wr_data = 1'b0;
    bus.rd_x    = '0;
    bus.rd_y    = '0;
    model_clear();
    repeat (2) @(negedge clk);
    do_reset();
    check_grid("reset");

    // read bounds and ignored out-of-range write
    write_cell(19, 14, 1'b1);
    write_cell(25, 3, 1'b1);
    read_chk("rd_corner", 19, 14, 1'b1);
    read_chk("rd_oob_x", 25, 3, 1'b0);
    read_chk("rd_oob_y", 5, 15, 1'b0);

    // blinker, two steps
    do_reset();
    write_cell(4, 5, 1'b1); write_cell(5, 5, 1'b1); write_cell(6, 5, 1'b1);
    step_gen(1'b0, 1'b0);
    check_grid("blinker1");
    step_gen(1'b0, 1'b0);
    check_grid("blinker2");
    chk("blinker_gen2", 32'(bus.gen_count), 32'd2);

    // block still life
    do_reset();
    write_cell(0, 0, 1'b1); write_cell(1, 0, 1'b1); write_cell(0, 1, 1'b1); write_cell(1, 1, 1'b1);
    step_gen(1'b0, 1'b0);
    check_grid("block");

    // toroidal wrap
    do_reset();
    write_cell(19, 7, 1'b1); write_cell(0, 7, 1'b1); write_cell(1, 7, 1'b1);
    step_gen(1'b0, 1'b0);
    check_grid("wrap");

    // writes and start while busy are ignored
    do_reset();
    write_cell(8, 8, 1'b1); write_cell(9, 8, 1'b1); write_cell(10, 8, 1'b1);
    step_gen(1'b1, 1'b0);
    read_chk("busy_write_ignored", 3, 3, 1'b0);
    check_grid("busy");

    // simultaneous seed write and start
    step_gen(1'b0, 1'b1);
    check_grid("cowrite");

    // reset in the middle of a scan
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (99) @(negedge clk);
    reset = 1'b1;
    #1;
    model_clear();
    chk("midscan_busy", 32'(bus.busy), 32'd0);
    chk("midscan_done", 32'(bus.done), 32'd0);
    chk("midscan_gen", 32'(bus.gen_count), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (310) begin
      @(negedge clk);
      if (bus.done) chk("midscan_no_done", 32'(bus.done), 32'd0);
    end
    check_grid("midscan");

    // random soups
    for (int r = 0; r < 3; r++) begin
      do_reset();
      for (int y = 0; y < ROWS; y++)
        for (int x = 0; x < COLS; x++)
          if ($urandom_range(0, 99) < 35) write_cell(x, y, 1'b1);
      step_gen(1'b0, 1'b0);
      check_grid($sformatf("rand%0d_g1", r));
      step_gen(1'b0, 1'b0);
      check_grid($sformatf("rand%0d_g2", r));
    end

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
